// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-latency memory between I-side block reads
// and D-side block reads or single-word writes; reads are issued as aligned BEATS-word bursts.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int BEATS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [15:0]               i_addr,
    output logic                      i_grant,
    output logic                      i_data_valid,
    output logic                      i_done,
    input  logic                      d_req,
    input  logic                      d_wr,
    input  logic [15:0]               d_addr,
    input  logic [15:0]               d_wdata,
    output logic                      d_grant,
    output logic                      d_data_valid,
    output logic                      d_done,
    output logic [15:0]               rdata,
    output logic [$clog2(BEATS)-1:0]  beat_idx,
    output logic                      mem_en,
    output logic                      mem_wr,
    output logic [15:0]               mem_addr,
    output logic [15:0]               mem_wdata,
    input  logic [15:0]               mem_rdata,
    input  logic                      mem_valid,
    output logic                      err
);
    localparam int AW = $clog2(BEATS);
    localparam logic [AW-1:0] CNT_LAST = AW'(BEATS - 1);

    if (MEM_LAT < 1 || BEATS < 2 || (1 << AW) != BEATS) begin : g_param_check
        $error("mem_arbiter: MEM_LAT must be >= 1 and BEATS a power of 2 >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic            owner_d_r, owner_nxt_s, last_d_r, win_d_s;
    logic [15:0]     addr_r, wdata_r;
    logic [AW-1:0]   issue_cnt_r, recv_cnt_r;
    logic            err_r, i_grant_r, d_grant_r;
    logic            ret_s, last_beat_s;

    // Beat address stays inside the aligned block: the low bits are replaced, never added.
    function automatic logic [15:0] beat_addr(input logic [15:0] a, input logic [AW-1:0] k);
        return {a[15:AW+1], k, 1'b0};
    endfunction

    assign i_grant = i_grant_r;
    assign d_grant = d_grant_r;
    assign err     = err_r;

    // Arbitration, next-state decode and per-cycle memory/return outputs
    always_comb begin
        win_d_s      = d_req & (~i_req | ~last_d_r);
        owner_nxt_s  = owner_d_r;
        state_nxt_s  = state_r;
        ret_s        = 1'b0;
        last_beat_s  = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        case (state_r)
            IDLE: begin
                owner_nxt_s = win_d_s;
                if (i_req | d_req) begin
                    if (win_d_s & d_wr) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE, DRAIN: begin
                ret_s       = mem_valid;
                last_beat_s = mem_valid & (recv_cnt_r == CNT_LAST);
                if (state_r == ISSUE) begin
                    mem_en   = 1'b1;
                    mem_addr = beat_addr(addr_r, issue_cnt_r);
                end else begin
                    mem_en   = 1'b0;
                end
                if (last_beat_s) begin
                    state_nxt_s = IDLE;
                end else if (state_r == ISSUE && issue_cnt_r == CNT_LAST) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_r;
                mem_wdata   = wdata_r;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (ret_s) begin
            rdata    = mem_rdata;
            beat_idx = recv_cnt_r;
        end else begin
            rdata    = 16'h0000;
            beat_idx = '0;
        end
        i_data_valid = ret_s & ~owner_d_r;
        d_data_valid = ret_s & owner_d_r;
        i_done       = last_beat_s & ~owner_d_r;
        d_done       = (last_beat_s & owner_d_r) | (state_r == WRITE);
    end

    // State, ownership, latched request, beat counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_d_r   <= 1'b0;
            last_d_r    <= 1'b0;
            addr_r      <= 16'h0000;
            wdata_r     <= 16'h0000;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
            err_r       <= 1'b0;
            i_grant_r   <= 1'b0;
            d_grant_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            owner_d_r <= owner_nxt_s;
            i_grant_r <= (state_nxt_s != IDLE) & ~owner_nxt_s;
            d_grant_r <= (state_nxt_s != IDLE) & owner_nxt_s;
            if (state_r == IDLE && (i_req | d_req)) begin
                last_d_r    <= win_d_s;
                addr_r      <= win_d_s ? d_addr : i_addr;
                wdata_r     <= d_wdata;
                issue_cnt_r <= '0;
                recv_cnt_r  <= '0;
            end else begin
                if (state_r == ISSUE) begin
                    issue_cnt_r <= issue_cnt_r + AW'(1);
                end else begin
                    issue_cnt_r <= issue_cnt_r;
                end
                if (ret_s) begin
                    recv_cnt_r <= recv_cnt_r + AW'(1);
                end else begin
                    recv_cnt_r <= recv_cnt_r;
                end
            end
            if (mem_valid && (state_r == IDLE || state_r == WRITE)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model, issue/return scoreboards fed at stimulus time,
// a table of single-requester transactions and hand-written round-robin/reset/error sequences.
module tb_mem_arbiter;
    localparam int MEM_LAT = 4;
    localparam int BEATS   = 8;
    localparam int BW      = 3;

    logic clk = 1'b0;
    logic rst, i_req, d_req, d_wr, inject;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [BW-1:0] beat_idx;
    logic mem_en, mem_wr, mem_valid, err;

    typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; } iss_t;
    typedef struct { logic own; logic [BW-1:0] beat; logic [15:0] data; logic last; } ret_t;
    typedef struct { logic is_d; logic wr; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_base; } vec_t;

    iss_t iss_q[$];
    ret_t ret_q[$];
    vec_t vecs[6];
    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int t_issue = -1;
    int t_data = -1;

    logic        pv [MEM_LAT];
    logic [15:0] pa [MEM_LAT];

    mem_arbiter #(.MEM_LAT(MEM_LAT), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid), .d_done(d_done),
        .rdata(rdata), .beat_idx(beat_idx),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Fixed-latency memory: a read accepted at an edge returns MEM_LAT cycles later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 16'h0000;
            end
        end else begin
            pv[0] <= mem_en & ~mem_wr;
            pa[0] <= mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign mem_valid = pv[MEM_LAT-1] | inject;
    assign mem_rdata = inject ? 16'h0BAD : (pv[MEM_LAT-1] ? mem_fn(pa[MEM_LAT-1]) : 16'h0000);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every memory issue and every returned beat is popped and compared
    always @(negedge clk) begin
        iss_t e;
        ret_t r;
        if (!rst) begin
            chk("grant_exclusive", 32'(i_grant & d_grant), 32'd0);
            if (mem_en) begin
                if (t_issue < 0) t_issue = cyc;
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_addr", 32'(mem_addr), 32'(e.addr));
                    chk("issue_wr", 32'(mem_wr), 32'(e.wr));
                    if (e.wr) begin
                        chk("write_data", 32'(mem_wdata), 32'(e.wdata));
                        chk("write_done", 32'(d_done), 32'd1);
                    end
                end
            end
            if (i_data_valid | d_data_valid) begin
                if (t_data < 0) t_data = cyc;
                if (ret_q.size() == 0) begin
                    chk("unexpected_data_valid", 32'(rdata), 32'hFFFF_FFFF);
                end else begin
                    r = ret_q.pop_front();
                    chk("return_owner", 32'({d_data_valid, i_data_valid}), r.own ? 32'd2 : 32'd1);
                    chk("beat_idx", 32'(beat_idx), 32'(r.beat));
                    chk("rdata", 32'(rdata), 32'(r.data));
                    chk("done_pulse", 32'({d_done, i_done}), r.last ? (r.own ? 32'd2 : 32'd1) : 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_read(input logic own, input logic [15:0] base);
        logic [15:0] a;
        for (int k = 0; k < BEATS; k++) begin
            a = base + 16'(2 * k);
            iss_q.push_back('{a, 1'b0, 16'h0000});
            ret_q.push_back('{own, BW'(k), mem_fn(a), (k == BEATS - 1)});
        end
    endtask

    // Called in the first grant cycle; returns in the first cycle the grant is low again
    task automatic track(input logic is_d, input int exp_cycles);
        int gc = 0;
        int dn = 0;
        for (int k = 0; k < 64; k++) begin
            if (!(is_d ? d_grant : i_grant)) break;
            gc++;
            if (is_d ? d_done : i_done) dn++;
            tick();
        end
        chk("grant_cycles", 32'(gc), 32'(exp_cycles));
        chk("done_count", 32'(dn), 32'd1);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ctl"}, 32'({i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done, mem_en, mem_wr, err}), 32'd0);
        chk({nm, "_bus"}, {mem_addr, mem_wdata}, 32'd0);
        chk({nm, "_ret"}, 32'({rdata, beat_idx}), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic got = 1'b0;
        t_issue = -1;
        t_data  = -1;
        if (v.wr) iss_q.push_back('{v.addr, 1'b1, v.wdata});
        else push_read(v.is_d, v.exp_base);
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (v.is_d ? d_grant : i_grant) begin
                got = 1'b1;
                break;
            end
        end
        chk("grant_seen", 32'(got), 32'd1);
        chk("other_grant_low", 32'(v.is_d ? i_grant : d_grant), 32'd0);
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        track(v.is_d, v.wr ? 1 : BEATS + MEM_LAT);
        chk("issue_q_empty", 32'(iss_q.size()), 32'd0);
        chk("ret_q_empty", 32'(ret_q.size()), 32'd0);
        if (!v.wr) chk("first_data_latency", 32'(t_data - t_issue), 32'(MEM_LAT));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        logic seen3;
        vecs[0] = '{1'b0, 1'b0, 16'h1236, 16'h0000, 16'h1230};
        vecs[1] = '{1'b0, 1'b0, 16'hFFFA, 16'h0000, 16'hFFF0};
        vecs[2] = '{1'b1, 1'b0, 16'h0101, 16'h0000, 16'h0100};
        vecs[3] = '{1'b1, 1'b1, 16'h0044, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h7FF0};
        vecs[5] = '{1'b0, 1'b0, 16'h001E, 16'h0000, 16'h0010};

        rst = 1'b1; inject = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 16'h2004; d_addr = 16'h300A; d_wdata = 16'h0000;
        repeat (3) tick();
        chk_idle("reset");

        // Both requesters held from reset: D wins the first tie, then strict alternation
        push_read(1'b1, 16'h3000);
        push_read(1'b0, 16'h2000);
        push_read(1'b1, 16'h3000);
        push_read(1'b0, 16'h2000);
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            exp_d = (g % 2 == 0);
            chk("rr_grant", 32'({d_grant, i_grant}), exp_d ? 32'd2 : 32'd1);
            if (g == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            track(exp_d, BEATS + MEM_LAT);
        end
        chk("rr_issue_q_empty", 32'(iss_q.size()), 32'd0);
        chk("rr_ret_q_empty", 32'(ret_q.size()), 32'd0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Stray mem_valid while idle: no data delivered, sticky error
        chk("err_clear", 32'(err), 32'd0);
        inject = 1'b1;
        #1;
        chk("inject_no_valid", 32'({i_data_valid, d_data_valid}), 32'd0);
        @(posedge clk);
        #1;
        inject = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        run_vec(vecs[0]);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in DRAIN after beat 3 with i_req held: dropped, then regranted from beat 0
        t_issue = -1; t_data = -1;
        push_read(1'b0, 16'h4000);
        i_req = 1'b1; i_addr = 16'h4006;
        tick();
        chk("rst_test_grant", 32'(i_grant), 32'd1);
        seen3 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (i_data_valid && beat_idx == 3'd3) begin
                seen3 = 1'b1;
                break;
            end
        end
        chk("beat3_seen", 32'(seen3), 32'd1);
        tick();
        chk("drain_state", 32'({i_grant, mem_en}), 32'd2);
        rst = 1'b1;
        iss_q.delete();
        ret_q.delete();
        tick();
        chk_idle("rst_mid_drain");
        rst = 1'b0;
        push_read(1'b0, 16'h4000);
        tick();
        chk("regrant_after_rst", 32'(i_grant), 32'd1);
        i_req = 1'b0;
        track(1'b0, BEATS + MEM_LAT);
        chk("rst_issue_q_empty", 32'(iss_q.size()), 32'd0);
        chk("rst_ret_q_empty", 32'(ret_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
